// File: rtl/code_entry_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : code_entry_conditioner
// Purpose  : Synchronises and debounces the code switches and check button,
//            normalises switch polarity and issues a one-cycle check strobe
//            with the code frozen alongside it, under an attempt budget and
//            a post-release cooldown.
// Revision : 1.0  initial release
// ============================================================================
module code_entry_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COOLDOWN_CYCLES = 25000000,
  parameter int MAX_ATTEMPTS    = 3
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       check,
  input  logic [7:0] p,
  input  logic       game_over,
  output logic [7:0] code,
  output logic       check_pulse,
  output logic [3:0] attempts_left,
  output logic       locked,
  output logic       busy
);

  localparam int            DW         = $clog2(DEBOUNCE_CYCLES);
  localparam int            CW         = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [DW-1:0] C_DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_CD_LOAD  = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [3:0]    C_MAX_ATT  = 4'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_COOL = 2'd2
  } state_t;

  // Bit 8 carries the check button, bits 7:0 the code switches.
  logic [8:0]    sync1_q, sync2_q;
  logic [8:0]    stable_q, stable_d;
  logic          chk_prev_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [7:0]    code_q, code_d;
  logic [3:0]    att_q, att_d;
  logic          pulse_q, pulse_d;

  logic [7:0]    norm_code;
  logic          chk_rise;
  logic          accept;

  // Two-flop synchroniser for all nine asynchronous inputs.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {check, p};
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_deb
    logic [DW-1:0] cnt_q;
    logic          differ;
    logic          expire;

    assign differ       = sync2_q[gi] ^ stable_q[gi];
    assign expire       = differ && (cnt_q == C_DB_LAST);
    assign stable_d[gi] = expire ? sync2_q[gi] : stable_q[gi];

    // Run-length counter: any agreement with the stable level restarts it.
    always_ff @(posedge sysclk) begin
      if (reset || !differ || expire) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Debounced levels plus the delayed check level used for edge detection.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      stable_q   <= '0;
      chk_prev_q <= 1'b0;
    end else begin
      stable_q   <= stable_d;
      chk_prev_q <= stable_q[8];
    end
  end

  // Upper nibble switches are wired active-low.
  assign norm_code = {~stable_q[7:4], stable_q[3:0]};
  assign chk_rise  = stable_q[8] && !chk_prev_q;
  assign accept    = (att_q != 4'd0) && !game_over;

  // Press/hold/cooldown sequencing and the registered strobe, code and budget.
  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    code_d  = code_q;
    att_d   = att_q;
    pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (chk_rise) begin
          state_d = S_HOLD;
          if (accept) begin
            code_d  = norm_code;
            pulse_d = 1'b1;
            att_d   = att_q - 4'd1;
          end
        end
      end
      S_HOLD: begin
        if (!stable_q[8]) begin
          state_d = S_COOL;
          cool_d  = C_CD_LOAD;
        end
      end
      S_COOL: begin
        if (cool_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cool_d = cool_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cool_q  <= '0;
      code_q  <= 8'h00;
      att_q   <= C_MAX_ATT;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      code_q  <= code_d;
      att_q   <= att_d;
      pulse_q <= pulse_d;
    end
  end

  assign code          = code_q;
  assign check_pulse   = pulse_q;
  assign attempts_left = att_q;
  assign locked        = (att_q == 4'd0) || game_over;
  assign busy          = (state_q == S_HOLD) || (state_q == S_COOL);

endmodule
`default_nettype wire

// File: doc/code_entry_conditioner.md
# code_entry_conditioner

Input-conditioning stage that sits directly upstream of the puzzle judge and countdown logic. It synchronises and debounces the eight raw code switches and the raw check push-button, normalises switch polarity into an 8-bit code word, and issues a single-cycle check strobe with the code frozen alongside it. It also enforces a per-game attempt budget and a post-check cooldown. Its outputs replace the judge's direct use of the raw button edge and raw switch levels.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required before a debounced level changes (≥2).
- COOLDOWN_CYCLES, 25000000: cycles after check release during which new presses are ignored (≥1).
- MAX_ATTEMPTS, 3: accepted checks per game (1..15).

- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- check  in  1  raw push-button; asynchronous, bouncy; high = pressed.
- p  in  8  raw switches p[7:0]; asynchronous, bouncy.
- game_over  in  1  from judge/timer; high = solved or timed out; freezes acceptance.
- code  out  8  code latched at the last accepted check.
- check_pulse  out  1  one-cycle strobe; code is valid in the same cycle.
- attempts_left  out  4  remaining accepted checks.
- locked  out  1  high when no further check can be accepted.
- busy  out  1  high in HOLD or COOLDOWN.

## Operation
- Synchroniser: two flops per input (9 inputs).
- Debouncer per input: one stable-level register and a counter. The counter increments each cycle the synced level differs from the stable level. It clears whenever they are equal.
- When the counter is at DEBOUNCE_CYCLES-1 and the levels still differ, the stable level takes the synced value and the counter clears.
- Counter width is $clog2(DEBOUNCE_CYCLES). It never wraps.
- Code normalisation: code_d = {~p_stable[7:4], p_stable[3:0]}. The upper nibble switches are active-low.
- FSM states:
  - IDLE: on a rising edge of the debounced check:
    - If accept is true, latch code <= code_d, pulse check_pulse, decrement attempts_left, and go to HOLD.
    - Otherwise go to HOLD without pulsing.
    - accept = !locked && !game_over.
  - HOLD: wait for debounced check low, then go to COOLDOWN and load the cooldown counter.
  - COOLDOWN: count COOLDOWN_CYCLES cycles, then go to IDLE. Rising edges of the debounced check are ignored. A press still held at expiry does not fire, because only an edge fires.
- locked = (attempts_left == 0) || game_over. This is combinational from registers.
- attempts_left saturates at 0 and never underflows.
- code holds its value between accepted checks.
- Switch changes during HOLD or COOLDOWN do not alter code.

## Timing
- Reset values:
  - code = 8'h00, check_pulse = 0, attempts_left = MAX_ATTEMPTS.
  - locked = game_over, busy = 0.
  - FSM in IDLE.
  - All stable levels = 0, all counters = 0, synchroniser flops = 0.
- Latency: raw check first sampled high at edge k (clean, no bounce) gives the stable level high at edge k+1+DEBOUNCE_CYCLES. check_pulse is then high for exactly one cycle after edge k+2+DEBOUNCE_CYCLES.
- Switch latency is identical: DEBOUNCE_CYCLES+1 edges to stable.
- A switch change that lands in the same cycle as the check edge uses the stable value in place before that edge.
- Any bounce reversal shorter than DEBOUNCE_CYCLES restarts the count. No change propagates.
- Simultaneous check edge and game_over rise in the same cycle: no pulse, no decrement.
- Reset mid-HOLD or mid-COOLDOWN: the FSM returns to IDLE the next cycle.
  - A button still physically held after reset needs a full debounce. Its stable level restarts at 0, so it produces a fresh edge and a pulse if accepted.
- Minimum spacing between two check_pulses is DEBOUNCE_CYCLES (release) + COOLDOWN_CYCLES + DEBOUNCE_CYCLES (press) + a few cycles.

## Test plan
- Use DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, MAX_ATTEMPTS=3 for all scenarios.
- Clean press: p=8'hA3, raw check high from edge 10 -> check_pulse a single cycle after edge 16, code=8'h53, attempts_left 3->2, busy=1.
- Bounce rejection: check toggles 1,0,1,0 each cycle, then settles high -> exactly one check_pulse, 6 edges after the settle sample. A 3-cycle glitch on p[0] leaves code unchanged.
- Cooldown: release, then re-press 3 cycles after HOLD exits -> no pulse. Re-press after COOLDOWN ends -> pulse, attempts_left=1.
- Attempt exhaustion: three accepted presses give attempts_left=0 and locked=1. A fourth press -> no pulse, code retains the third value.
- game_over: assert game_over=1 while attempts_left=2, then press -> no pulse, locked=1, attempts_left stays 2.
- Reset mid-COOLDOWN with check held -> attempts_left=3, busy=0 next cycle. The held button yields a pulse 6 edges later.
